// File: rtl/pkt_buf_pkg.sv
// Shared types for the packet buffer write controller.
package pkt_buf_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DROP} state_e;

  function automatic int swidth_f(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/slot_desc_ring.sv
// Ring of committed-packet descriptors: per-slot length, write/read pointers and occupancy.
module slot_desc_ring #(
  parameter int AWIDTH = 4,
  parameter int SLOTS  = 4,
  parameter int SWIDTH = 2
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              clr_i,
  input  logic              commit_i,
  input  logic [AWIDTH:0]   commit_len_i,
  input  logic              release_i,
  output logic [SWIDTH-1:0] wr_ptr_o,
  output logic [SWIDTH-1:0] rd_ptr_o,
  output logic [AWIDTH:0]   rd_len_o,
  output logic              valid_o,
  output logic              full_o
);

  localparam logic [SWIDTH:0] FULL_CNT = (SWIDTH+1)'(SLOTS);

  logic [SLOTS-1:0][AWIDTH:0] len_q, len_d;
  logic [SWIDTH-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SWIDTH:0]            cnt_q, cnt_d;
  logic                       rel;

  assign valid_o  = (cnt_q != '0);
  assign full_o   = (cnt_q == FULL_CNT);
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign rd_len_o = len_q[rd_ptr_q];
  assign rel      = release_i & valid_o;

  always_comb begin
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      len_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (commit_i) begin
        len_d[wr_ptr_q] = commit_len_i;
        wr_ptr_d        = wr_ptr_q + SWIDTH'(1);
      end
      if (rel) rd_ptr_d = rd_ptr_q + SWIDTH'(1);
      // Simultaneous commit and release cancel out in the count.
      if (commit_i && !rel)      cnt_d = cnt_q + (SWIDTH+1)'(1);
      else if (rel && !commit_i) cnt_d = cnt_q - (SWIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      len_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/pkt_buf_wr_ctrl.sv
// Write-side controller: turns a val/sop/eop stream into RAM writes into slots,
// commits complete packets to the descriptor ring and drops bad ones.
module pkt_buf_wr_ctrl
  import pkt_buf_pkg::*;
#(
  parameter int AWIDTH = 4,
  parameter int SLOTS  = 4,
  parameter int SWIDTH = swidth_f(SLOTS),
  parameter int CWIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     val_i,
  input  logic                     sop_i,
  input  logic                     eop_i,
  input  logic                     clr_i,
  output logic                     wren_o,
  output logic [SWIDTH+AWIDTH-1:0] wraddr_o,
  output logic                     rd_valid_o,
  output logic [SWIDTH-1:0]        rd_slot_o,
  output logic [AWIDTH:0]          rd_len_o,
  input  logic                     rd_done_i,
  output logic                     full_o,
  output logic [CWIDTH-1:0]        drop_cnt_o
);

  localparam logic [AWIDTH-1:0] OFF_LAST = '1;

  state_e                   state_q, state_d;
  logic [AWIDTH-1:0]        off_q, off_d;
  logic                     wren_q, wren_d;
  logic [SWIDTH+AWIDTH-1:0] wraddr_q, wraddr_d;
  logic [CWIDTH-1:0]        drop_q, drop_d;
  logic [CWIDTH:0]          drop_sum;
  logic [1:0]               drop_inc;
  logic                     commit, start;
  logic [AWIDTH:0]          commit_len;
  logic [SWIDTH-1:0]        wr_ptr;
  logic                     full;

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    wren_d     = 1'b0;
    wraddr_d   = wraddr_q;
    commit     = 1'b0;
    commit_len = '0;
    drop_inc   = 2'd0;
    start      = 1'b0;

    if (val_i) begin
      unique case (state_q)
        ST_IDLE: start = sop_i;
        ST_WRITE: begin
          if (sop_i) begin
            drop_inc = 2'd1;
            start    = 1'b1;
          end else begin
            wren_d   = 1'b1;
            wraddr_d = {wr_ptr, off_q};
            if (eop_i) begin
              commit     = 1'b1;
              commit_len = {1'b0, off_q} + (AWIDTH+1)'(1);
              state_d    = ST_IDLE;
            end else if (off_q == OFF_LAST) begin
              state_d = ST_DROP;
            end else begin
              off_d = off_q + AWIDTH'(1);
            end
          end
        end
        ST_DROP: begin
          if (sop_i) begin
            drop_inc = 2'd1;
            start    = 1'b1;
          end else if (eop_i) begin
            drop_inc = 2'd1;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A sop beat from any state; full is only looked at here.
    if (start) begin
      if (full) begin
        if (eop_i) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end else begin
        wren_d   = 1'b1;
        wraddr_d = {wr_ptr, {AWIDTH{1'b0}}};
        if (eop_i) begin
          commit     = 1'b1;
          commit_len = (AWIDTH+1)'(1);
          state_d    = ST_IDLE;
        end else begin
          off_d   = AWIDTH'(1);
          state_d = ST_WRITE;
        end
      end
    end

    drop_sum = {1'b0, drop_q} + (CWIDTH+1)'(drop_inc);
    drop_d   = drop_sum[CWIDTH] ? '1 : drop_sum[CWIDTH-1:0];

    if (clr_i) begin
      state_d  = ST_IDLE;
      off_d    = '0;
      wren_d   = 1'b0;
      wraddr_d = '0;
      commit   = 1'b0;
      drop_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= ST_IDLE;
      off_q    <= '0;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      drop_q   <= drop_d;
    end
  end

  slot_desc_ring #(.AWIDTH(AWIDTH), .SLOTS(SLOTS), .SWIDTH(SWIDTH)) u_ring (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .clr_i        (clr_i),
    .commit_i     (commit),
    .commit_len_i (commit_len),
    .release_i    (rd_done_i),
    .wr_ptr_o     (wr_ptr),
    .rd_ptr_o     (rd_slot_o),
    .rd_len_o     (rd_len_o),
    .valid_o      (rd_valid_o),
    .full_o       (full)
  );

  assign full_o     = full;
  assign wren_o     = wren_q;
  assign wraddr_o   = wraddr_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_pkt_buf_wr_ctrl.sv
// Scoreboard bench for pkt_buf_wr_ctrl against a packet-level reference model.
module tb_pkt_buf_wr_ctrl;
  localparam int AW = 4, SL = 4, SW = 2, CW = 16;
  localparam int SZ = 1 << AW;

  logic          clk = 0, arst = 1;
  logic          val = 0, sop = 0, eop = 0, clr = 0, rd_done = 0;
  logic          wren_o, rd_valid_o, full_o;
  logic [SW+AW-1:0] wraddr_o;
  logic [SW-1:0] rd_slot_o;
  logic [AW:0]   rd_len_o;
  logic [CW-1:0] drop_cnt_o;

  pkt_buf_wr_ctrl #(.AWIDTH(AW), .SLOTS(SL), .CWIDTH(CW)) dut (
    .clk_i(clk), .arst_i(arst), .val_i(val), .sop_i(sop), .eop_i(eop), .clr_i(clr),
    .wren_o(wren_o), .wraddr_o(wraddr_o), .rd_valid_o(rd_valid_o), .rd_slot_o(rd_slot_o),
    .rd_len_o(rd_len_o), .rd_done_i(rd_done), .full_o(full_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {bit wren; int addr; bit valid; int slot; int len; bit full; int drop;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  // Reference model: packet in progress (open/discarding), committed slot count, stored lengths.
  int  m_wslot, m_rslot, m_cnt, m_drop, m_off;
  bit  m_open, m_discard;
  int  m_len[SL];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_wslot = 0; m_rslot = 0; m_cnt = 0; m_drop = 0; m_off = 0;
    m_open = 0; m_discard = 0;
    for (int i = 0; i < SL; i++) m_len[i] = 0;
  endfunction

  function automatic void m_dropped();
    if (m_drop < (1 << CW) - 1) m_drop++;
  endfunction

  function automatic void m_commit(input int len);
    m_len[m_wslot] = len;
    m_wslot = (m_wslot + 1) % SL;
    m_cnt++;
  endfunction

  function automatic exp_t m_step(input bit v, input bit s, input bit e, input bit d, input bit c);
    exp_t x;
    bit   rel, st;
    x.wren = 0; x.addr = 0;
    rel = d && (m_cnt > 0);
    st  = 0;
    if (c) m_reset();
    else begin
      if (v) begin
        if (s) begin
          if (m_open || m_discard) m_dropped();
          st = 1;
        end else if (m_open) begin
          x.wren = 1; x.addr = m_wslot * SZ + m_off;
          if (e) begin m_commit(m_off + 1); m_open = 0; end
          else begin
            m_off++;
            if (m_off == SZ) begin m_open = 0; m_discard = 1; end
          end
        end else if (m_discard && e) begin
          m_dropped(); m_discard = 0;
        end
        if (st) begin
          m_open = 0; m_discard = 0;
          if (m_cnt == SL) begin
            if (e) m_dropped(); else m_discard = 1;
          end else begin
            x.wren = 1; x.addr = m_wslot * SZ;
            if (e) m_commit(1);
            else begin m_open = 1; m_off = 1; end
          end
        end
      end
      if (rel) begin m_rslot = (m_rslot + 1) % SL; m_cnt--; end
    end
    x.valid = m_cnt > 0; x.slot = m_rslot; x.len = m_len[m_rslot];
    x.full = m_cnt == SL; x.drop = m_drop;
    return x;
  endfunction

  // Monitor: one expectation per driven cycle, compared a half cycle after the edge.
  always @(negedge clk) begin
    if (!arst && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("wren", wren_o, e.wren);
      if (e.wren) chk("wraddr", wraddr_o, e.addr);
      chk("rd_valid", rd_valid_o, e.valid);
      chk("rd_slot", rd_slot_o, e.slot);
      chk("rd_len", rd_len_o, e.len);
      chk("full", full_o, e.full);
      chk("drop_cnt", drop_cnt_o, e.drop);
    end
  end

  task automatic beat(input bit v, input bit s, input bit e, input bit d = 0, input bit c = 0);
    @(negedge clk); #1;
    val = v; sop = s; eop = e; rd_done = d; clr = c;
    sb.push_back(m_step(v, s, e, d, c));
  endtask

  task automatic pkt(input int n, input bit d_last = 0);
    if (n == 1) beat(1, 1, 1, d_last);
    else begin
      beat(1, 1, 0);
      for (int i = 0; i < n - 2; i++) beat(1, 0, 0);
      beat(1, 0, 1, d_last);
    end
  endtask

  task automatic settle();
    beat(0, 0, 0);
    @(negedge clk); #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wren"}, wren_o, 0);
    chk({tag, "_wraddr"}, wraddr_o, 0);
    chk({tag, "_valid"}, rd_valid_o, 0);
    chk({tag, "_slot"}, rd_slot_o, 0);
    chk({tag, "_len"}, rd_len_o, 0);
    chk({tag, "_full"}, full_o, 0);
    chk({tag, "_drop"}, drop_cnt_o, 0);
  endtask

  initial begin
    m_reset();
    #12; chk_reset("reset");
    @(negedge clk); #1; arst = 0;

    // 3-word packet
    pkt(3); settle();
    chk("s1_valid", rd_valid_o, 1); chk("s1_slot", rd_slot_o, 0); chk("s1_len", rd_len_o, 3);

    // 16-word then 17-word packet
    beat(0, 0, 0, 0, 1);
    pkt(16); pkt(17); settle();
    chk("s2_len", rd_len_o, 16); chk("s2_drop", drop_cnt_o, 1);

    // fill all slots, overflow one, release one
    beat(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) pkt(2);
    settle(); chk("s3_full", full_o, 1);
    pkt(2); settle(); chk("s3_drop", drop_cnt_o, 1);
    beat(0, 0, 0, 1); settle();
    chk("s3_full_after", full_o, 0); chk("s3_slot", rd_slot_o, 1);

    // restart mid-packet
    beat(0, 0, 0, 0, 1);
    beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 0);
    beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 1); settle();
    chk("s4_drop", drop_cnt_o, 1); chk("s4_len", rd_len_o, 3);

    // commit and release together, then release while empty
    beat(0, 0, 0, 0, 1);
    pkt(2); pkt(3); pkt(4, 1); settle();
    chk("s5_slot", rd_slot_o, 1); chk("s5_len", rd_len_o, 3);
    beat(0, 0, 0, 0, 1); beat(0, 0, 0, 1); settle();
    chk("s5_empty_slot", rd_slot_o, 0);

    // clear mid-packet with two slots committed
    pkt(2); pkt(2); beat(1, 1, 0); beat(1, 0, 0);
    beat(1, 0, 0, 0, 1); settle(); chk_reset("clr");
    pkt(2);

    // async reset mid-write
    beat(1, 1, 0); beat(1, 0, 0);
    @(negedge clk); #3;
    arst = 1; val = 0; sop = 0; eop = 0; rd_done = 0; clr = 0;
    sb.delete(); m_reset();
    #1; chk_reset("arst");
    @(negedge clk); #1; arst = 0;
    pkt(2); settle(); chk("post_arst_len", rd_len_o, 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      beat($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    beat(0, 0, 0); beat(0, 0, 0);
    repeat (2) @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_buf_wr_ctrl.md
# pkt_buf_wr_ctrl

Write-side controller for a multi-slot packet buffer RAM. It is the parametrised successor of the single-packet write-address controller. The RAM is split into `SLOTS` fixed-size slots, and each slot holds one packet of up to `2**AWIDTH` words. The block generates RAM write enable and address from a val/sop/eop stream, commits complete packets with their length into a ring of slot descriptors, and hands those descriptors to a read-side consumer. Oversized, malformed and no-room packets are dropped.

## Interface
Parameters:
- `AWIDTH`, 4: word-offset width inside a slot; slot size is `2**AWIDTH` words.
- `SLOTS`, 4: number of packet slots; a power of 2, at least 2.
- `SWIDTH`, `$clog2(SLOTS)`: derived; slot index width.
- `CWIDTH`, 16: drop counter width.

Ports:
- `clk_i` in 1: clock.
- `arst_i` in 1: reset. Asynchronous, active-high.
- `val_i` in 1: input word valid.
- `sop_i` in 1: start of packet; qualified by `val_i`.
- `eop_i` in 1: end of packet; qualified by `val_i`.
- `clr_i` in 1: synchronous flush of all state.
- `wren_o` out 1: RAM write enable.
- `wraddr_o` out `SWIDTH+AWIDTH`: RAM write address, formed as {slot, offset}.
- `rd_valid_o` out 1: at least one committed packet is available.
- `rd_slot_o` out `SWIDTH`: slot index of the oldest committed packet.
- `rd_len_o` out `AWIDTH+1`: word count of that packet, from 1 to `2**AWIDTH`.
- `rd_done_i` in 1: consumer releases the oldest slot; acted on only when `rd_valid_o` is high.
- `full_o` out 1: all slots are committed.
- `drop_cnt_o` out `CWIDTH`: number of dropped packets; saturates at its maximum.

## Operation
- FSM states: IDLE, WRITE, DROP.
- IDLE:
  - `val&sop&!full`: write the word at offset 0 of slot `wr_ptr`.
    - If `eop` is also set, commit a packet of length 1 and stay in IDLE.
    - Otherwise go to WRITE with offset 1.
  - `val&sop&full`: write nothing. If `eop` is set, increment the drop counter and stay; otherwise go to DROP.
  - `val&!sop`: ignored.
- WRITE:
  - `val&!sop&!eop`: write the word and increment the offset.
    - If this word was written at offset `2**AWIDTH-1`, go to DROP. The slot is not committed.
  - `val&eop&!sop`: write the word and commit with length = offset+1, which can be `2**AWIDTH`. Go to IDLE.
  - `val&sop`: abandon the current packet, increment the drop counter, and restart at offset 0 of the same slot, treated exactly as IDLE start.
- DROP:
  - `val&eop&!sop`: increment the drop counter and go to IDLE.
  - `val&sop`: increment the drop counter, then handle the beat as an IDLE start.
  - Nothing is written while in DROP.
- Commit: store the length in the descriptor of `wr_ptr`, then increment `wr_ptr` (wrapping modulo `SLOTS`) and `count`.
- Release: `rd_done_i&rd_valid_o` increments `rd_ptr` (wrapping) and decrements `count`.
  - Commit and release in the same cycle leave `count` unchanged.
  - `rd_done_i` with `rd_valid_o=0` is ignored.
- Derived outputs:
  - `rd_valid_o = count!=0`.
  - `full_o = count==SLOTS`.
  - `rd_slot_o = rd_ptr`; `rd_len_o` is the length stored for `rd_ptr`.
- `full_o` is sampled at sop only. A packet already in WRITE always owns its slot, because `wr_ptr` never points at a committed slot while `count<SLOTS`.
- `clr_i` has priority over all stream inputs and `rd_done_i`. It resets the FSM, pointers, count and drop counter, and discards the current beat.

## Timing
- `wren_o` and `wraddr_o` are registered and appear 1 cycle after the accepted beat. Upstream delays RAM data by one cycle to match.
- The commit is visible 1 cycle after the eop beat: `rd_valid_o`, `full_o` and `rd_len_o` update in that cycle. This is the same cycle the last word's `wren_o` is asserted.
- A release takes effect on the next cycle.
- Reset values: `wren_o=0`, `wraddr_o=0`, `rd_valid_o=0`, `rd_slot_o=0`, `rd_len_o=0`, `full_o=0`, `drop_cnt_o=0`; FSM in IDLE.
- Reset mid-packet discards the packet without counting a drop.
- Back-to-back packets are supported with no idle cycle between eop and the next sop.

## Structure
- Package `pkt_buf_pkg`: FSM state enum and the `SWIDTH` derivation function.
- Sub-module `slot_desc_ring`: the descriptor store, holding the length array, `wr_ptr`, `rd_ptr` and `count`, with commit and release ports and the `full`/`valid` flags.

## Test plan
All scenarios use `AWIDTH=4` and `SLOTS=4`.
- Reset, then one 3-word packet → writes at addresses 0, 1, 2. One cycle after eop: `rd_valid_o=1`, `rd_slot_o=0`, `rd_len_o=3`.
- 16-word packet followed by a 17-word packet → first is committed with `rd_len_o=16`. Second writes addresses 16..31, is not committed, and `drop_cnt_o=1`.
- Four 2-word packets with no release → `full_o=1`. A fifth packet is dropped with no `wren_o` (`drop_cnt_o=1`). One `rd_done_i` → `full_o=0`, `rd_slot_o=1`.
- sop at beat 0, sop again at beat 3, eop at beat 5 → `drop_cnt_o=1`. Committed length is 3, and the restart rewrites offset 0 of the same slot.
- Commit and `rd_done_i` in the same cycle with count=2 → count stays 2 and both pointers advance. `rd_done_i` while empty → no change.
- `clr_i` mid-packet with 2 slots committed, then `arst_i` asserted asynchronously mid-write → all outputs return to their reset values, and the next packet starts at address 0.
